zloader: RTL and testbench
==========================

# zloader

Program loader that sits upstream of the zephyr core. It receives a 16-byte program image over a valid/ready byte stream and writes it into the 16x8 program RAM. It then checks a trailing checksum byte and releases the core from reset only if the image is intact. While `CORE_RESET` is high, the top level muxes the RAM ports to this block; otherwise they go to the core.

## Interface
Parameters:
- `DEPTH`, 16, number of program bytes per image; equals RAM size.
- `ADDR_W`, 4, RAM address width; must satisfy 2^ADDR_W >= DEPTH.
- `DATA_W`, 8, byte width.

Ports:
- `CLK`  in  1  the single clock; all state changes on its rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  begins a load; sampled only in IDLE, DONE and ERR.
- `IN_DATA`  in  DATA_W  stream byte.
- `IN_VALID`  in  1  `IN_DATA` is valid.
- `IN_READY`  out  1  loader accepts a byte; a transfer occurs at the edge where `IN_VALID` and `IN_READY` are both high.
- `RAM_ADDR`  out  ADDR_W  RAM address.
- `RAM_OP`  out  1  RAM write strobe; 1 = write, 0 = read.
- `RAM_DATA_IN`  out  DATA_W  RAM write data.
- `CORE_RESET`  out  1  active-high reset to the core; also the RAM mux select.
- `DONE`  out  1  image loaded and checksum good.
- `ERROR`  out  1  checksum mismatch.
- `CHECKSUM`  out  DATA_W  mod-256 sum of the DEPTH program bytes of the last completed load.

## Operation
All outputs are registered. Internal state:
- `count`: ADDR_W bits, index of the current program byte.
- `sum`: DATA_W bits, running mod-256 sum of accepted program bytes.

States:
- IDLE (reset state).
  - `CORE_RESET`=1, `IN_READY`=0.
  - On `START`=1: `count`<=0, `sum`<=0, `DONE`<=0, `ERROR`<=0, `IN_READY`<=1, go to RECV.
- RECV. `IN_READY`=1. On a transfer:
  - `RAM_ADDR`<=`count`, `RAM_DATA_IN`<=`IN_DATA`, `RAM_OP`<=1.
  - `sum`<=`sum`+`IN_DATA`, truncated to DATA_W bits.
  - `IN_READY`<=0, go to WRITE.
  - With no transfer, hold all registers.
- WRITE (exactly one cycle). `RAM_OP` is 1 for this cycle; address and data are stable. At its end `RAM_OP`<=0, then:
  - if `count`==DEPTH-1: `IN_READY`<=1, go to CSUM;
  - else: `count`<=`count`+1, `IN_READY`<=1, go to RECV.
- CSUM. `IN_READY`=1. On a transfer: `IN_READY`<=0, `CHECKSUM`<=`sum`, then:
  - if (`sum`+`IN_DATA`) mod 256 == 0: `DONE`<=1, `CORE_RESET`<=0, go to DONE;
  - else: `ERROR`<=1, go to ERR; `CORE_RESET` stays 1.
  - No RAM write occurs in this state.
- DONE.
  - Core runs; `DONE`=1, `CORE_RESET`=0, `IN_READY`=0.
  - On `START`: `CORE_RESET`<=1, `DONE`<=0, then same actions as IDLE+`START`.
- ERR.
  - `ERROR`=1, `CORE_RESET`=1, `IN_READY`=0.
  - On `START`: `ERROR`<=0, then same actions as IDLE+`START`.

Boundary rules:
- `START` in RECV, WRITE or CSUM is ignored.
- `IN_VALID` while `IN_READY`=0 is not a transfer; the byte is not consumed.
- `count` never wraps; the only exit at DEPTH-1 is to CSUM.
- `RAM_ADDR` and `RAM_DATA_IN` hold their last values outside WRITE.

## Timing
- Reset values (asynchronous on `RESET_N`=0):
  - state IDLE, `count`=0, `sum`=0;
  - `IN_READY`=0, `RAM_OP`=0, `RAM_ADDR`=0, `RAM_DATA_IN`=0;
  - `CORE_RESET`=1, `DONE`=0, `ERROR`=0, `CHECKSUM`=0.
- Reset mid-load returns to these values immediately and holds the core in reset. RAM contents already written are not cleared.
- Throughput is at most one byte per 2 cycles, because every accepted byte is followed by one WRITE cycle with `IN_READY`=0.
- With `START` sampled at edge 0 and `IN_VALID` held high:
  - program byte k is accepted at edge 1+2k;
  - `RAM_OP`=1 in the cycle after edge 1+2k;
  - the checksum byte is accepted at edge 33;
  - `DONE`=1 and `CORE_RESET`=0 after edge 33.
- `IN_READY` falls in the cycle after each acceptance edge. It rises again one cycle later.

## Test plan
- Reset: assert `RESET_N`=0 mid-cycle -> every output takes its reset value at once, without waiting for a `CLK` edge.
- Good load: `START`, then bytes 0x00..0x0F and checksum 0x88, `IN_VALID` held high -> 16 writes with addr k, data k, each with `RAM_OP` high exactly one cycle; `CHECKSUM`=0x78; `DONE`=1 and `CORE_RESET`=0 after edge 33.
- Bad checksum: same image with checksum 0x89 -> `ERROR`=1, `DONE`=0, `CORE_RESET` stays 1; `START` plus the good image -> `ERROR` cleared, then `DONE`=1.
- Stalls: random `IN_VALID` gaps on the good image -> `IN_READY` stays high through gaps; no writes during gaps; RAM contents and addresses identical to the no-stall case.
- Mid-load reset: `RESET_N` pulsed low after byte 5 is written -> outputs at reset values, `CORE_RESET`=1; a fresh `START` and full good load -> `DONE`=1 with `CHECKSUM`=0x78.
- START handling:
  - `START` pulsed during RECV -> no effect on `count` or `sum`.
  - `START` in DONE -> `CORE_RESET`=1 and `DONE`=0 after the next edge; a second good load completes.

Source files
------------

// File: rtl/zloader.sv
// zloader: streams a DEPTH-byte program image into the program RAM, one
// byte per two cycles, then validates a trailing checksum byte and
// releases the core from reset only when the image sums to zero mod 2^DATA_W.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; core held in reset, waiting for START
// RECV    | IN_READY high, waiting for the next program byte
// WRITE   | single RAM write cycle for the byte just accepted
// CSUM    | IN_READY high, waiting for the trailing checksum byte
// DONE    | image good; core running until the next START
// ERR     | checksum bad; core held in reset until the next START
module zloader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_OP,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  output logic              CORE_RESET,
  output logic              DONE,
  output logic              ERROR,
  output logic [DATA_W-1:0] CHECKSUM
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_plus_in;
  logic              xfer;

  // Handshake and the running sum including the byte on the bus.
  always_comb begin
    xfer        = IN_VALID && IN_READY;
    sum_plus_in = sum + IN_DATA;
  end

  // Load sequencer; every output is a register updated here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      count       <= '0;
      sum         <= '0;
      IN_READY    <= 1'b0;
      RAM_OP      <= 1'b0;
      RAM_ADDR    <= '0;
      RAM_DATA_IN <= '0;
      CORE_RESET  <= 1'b1;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      CHECKSUM    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Restart from any resting state re-asserts core reset first.
          if (START) begin
            count      <= '0;
            sum        <= '0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            CORE_RESET <= 1'b1;
            IN_READY   <= 1'b1;
            state      <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (xfer) begin
            RAM_ADDR    <= count;
            RAM_DATA_IN <= IN_DATA;
            RAM_OP      <= 1'b1;
            sum         <= sum_plus_in;
            IN_READY    <= 1'b0;
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          RAM_OP   <= 1'b0;
          IN_READY <= 1'b1;
          if (count == LAST_IDX) begin
            state <= ST_CSUM;
          end else begin
            count <= count + 1'b1;
            state <= ST_RECV;
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            IN_READY <= 1'b0;
            CHECKSUM <= sum;
            if (sum_plus_in == '0) begin
              DONE       <= 1'b1;
              CORE_RESET <= 1'b0;
              state      <= ST_DONE;
            end else begin
              ERROR <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zloader.sv
// Directed testbench for zloader: good/bad images, stalls, START handling
// and asynchronous reset, with a small RAM model behind the write port.
module tb_zloader;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] RAM_ADDR;
  logic       RAM_OP;
  logic [7:0] RAM_DATA_IN;
  logic       CORE_RESET;
  logic       DONE;
  logic       ERROR;
  logic [7:0] CHECKSUM;

  int errors = 0;
  int checks = 0;
  logic [7:0] ram [16];
  int acc_edge;

  zloader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RAM_ADDR(RAM_ADDR), .RAM_OP(RAM_OP), .RAM_DATA_IN(RAM_DATA_IN),
    .CORE_RESET(CORE_RESET), .DONE(DONE), .ERROR(ERROR), .CHECKSUM(CHECKSUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: written on the rising edge while the write strobe is high.
  always @(posedge CLK) begin
    if (RAM_OP) ram[RAM_ADDR] <= RAM_DATA_IN;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  IN_READY, 0);
    chk({tag, "_op"},   RAM_OP, 0);
    chk({tag, "_addr"}, RAM_ADDR, 0);
    chk({tag, "_data"}, RAM_DATA_IN, 0);
    chk({tag, "_crst"}, CORE_RESET, 1);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"},  ERROR, 0);
    chk({tag, "_csum"}, CHECKSUM, 0);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = 8'hEE;
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, {24'd0, ram[i]}, i);
  endtask

  // Pulses START, then streams bytes 0..15 plus csum. Called at a negedge.
  // abort_at < 17 stops after that many bytes are accepted (in the WRITE cycle).
  task automatic run_load(input logic [7:0] csum, input bit stalls, input bit poke,
                          input int abort_at, output int accept_edge);
    int  idx = 0;
    int  cyc = 0;
    bit  xfer;
    bit  rdy_before;
    accept_edge = -1;
    START = 1'b1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    chk("start_rdy",  IN_READY, 1);
    chk("start_crst", CORE_RESET, 1);
    chk("start_done", DONE, 0);
    chk("start_err",  ERROR, 0);
    while (idx < abort_at && cyc < 400) begin
      IN_DATA    = (idx < 16) ? idx[7:0] : csum;
      IN_VALID   = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      START      = poke && (idx == 3) && IN_READY;
      xfer       = IN_VALID && IN_READY;
      rdy_before = IN_READY;
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      if (xfer) begin
        if (idx < 16) begin
          chk("wr_op",   RAM_OP, 1);
          chk("wr_addr", RAM_ADDR, idx);
          chk("wr_data", RAM_DATA_IN, idx);
          chk("wr_rdy",  IN_READY, 0);
        end else begin
          accept_edge = cyc;
          chk("cs_op", RAM_OP, 0);
        end
        idx++;
      end else if (rdy_before) begin
        chk("stall_rdy", IN_READY, 1);
        chk("stall_op",  RAM_OP, 0);
      end else begin
        chk("post_wr_op",  RAM_OP, 0);
        chk("post_wr_rdy", IN_READY, 1);
      end
    end
    IN_VALID = 1'b0;
    chk("load_bytes", idx, abort_at);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_crst"}, CORE_RESET, 0);
    chk({tag, "_err"},  ERROR, 0);
    chk({tag, "_rdy"},  IN_READY, 0);
    chk({tag, "_csum"}, CHECKSUM, 8'h78);
  endtask

  initial begin
    RESET_N  = 1'b0;
    START    = 1'b0;
    IN_DATA  = 8'h00;
    IN_VALID = 1'b0;
    clear_ram();
    #12;
    chk_reset_vals("por");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk_reset_vals("idle");

    // IN_VALID in IDLE is not consumed and START is absent: nothing moves.
    IN_VALID = 1'b1;
    IN_DATA  = 8'h55;
    @(negedge CLK);
    chk("idle_valid_rdy", IN_READY, 0);
    chk("idle_valid_op",  RAM_OP, 0);
    IN_VALID = 1'b0;

    // Good load, no stalls: checksum byte accepted at edge 33.
    run_load(8'h88, 1'b0, 1'b0, 17, acc_edge);
    chk("good_edge", acc_edge, 33);
    check_done("good");
    check_ram("good_ram");

    // START in DONE: reset re-asserted after one edge; then bad checksum.
    clear_ram();
    run_load(8'h89, 1'b0, 1'b0, 17, acc_edge);
    chk("bad_err",  ERROR, 1);
    chk("bad_done", DONE, 0);
    chk("bad_crst", CORE_RESET, 1);
    chk("bad_csum", CHECKSUM, 8'h78);
    @(negedge CLK);
    chk("err_hold_crst", CORE_RESET, 1);
    chk("err_hold_err",  ERROR, 1);

    // Recovery from ERR with the good image.
    run_load(8'h88, 1'b0, 1'b0, 17, acc_edge);
    check_done("recover");

    // Random stalls on the good image.
    clear_ram();
    run_load(8'h88, 1'b1, 1'b0, 17, acc_edge);
    check_done("stall");
    check_ram("stall_ram");

    // START pulsed during RECV is ignored.
    run_load(8'h88, 1'b0, 1'b1, 17, acc_edge);
    chk("poke_edge", acc_edge, 33);
    check_done("poke");

    // Mid-load reset after byte 5 is written, asserted mid-cycle.
    run_load(8'h88, 1'b0, 1'b0, 6, acc_edge);
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk_reset_vals("midrst_idle");
    run_load(8'h88, 1'b0, 1'b0, 17, acc_edge);
    chk("after_rst_edge", acc_edge, 33);
    check_done("after_rst");

    // Asynchronous reset from DONE: outputs change without a clock edge.
    #2;
    RESET_N = 1'b0;
    #1;
    chk_reset_vals("done_rst");
    @(negedge CLK);
    RESET_N = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
